adder_arbiter: RTL and testbench

Round-robin arbiter that shares one registered WIDTH-bit adder (inputs a, b, clk; output sum; fixed pipeline latency ADD_LAT) among NREQ requesters. Each requester presents operands with a valid/ready handshake. The arbiter issues at most one add per cycle into the adder pipeline and returns each result tagged one-hot to its originator. Sits between client blocks and the shared adder instance.

---
 rtl/adder_arbiter_if.sv | 23 ++
 rtl/adder_arbiter.sv | 80 ++++++++
 tb/tb_adder_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between client blocks and the shared-adder arbiter.
// Operands are packed flat: requester i occupies bits [i*WIDTH +: WIDTH].
interface adder_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_sum
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_sum
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among NREQ requesters.
// One grant per cycle; the one-hot grant travels down a tag pipeline matching
// the adder latency and comes back out as rsp_valid alongside add_sum.
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_arbiter_if.slave   bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic [2:0]       in_flight
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [NREQ-1:0]                gnt;
  logic [ADD_LAT-1:0][NREQ-1:0]   tag_q, tag_d;
  logic [2:0]                     in_flight_q, in_flight_d;
  logic                           issue, ret;

  // Scan from ptr upward (mod NREQ); first valid wins and steers its operands
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    ptr_d = ptr_q;
    add_a = '0;
    add_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && rst_n && bus.req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        add_a    = bus.req_a[idx*WIDTH +: WIDTH];
        add_b    = bus.req_b[idx*WIDTH +: WIDTH];
        ptr_d    = (idx == NREQ-1) ? '0 : PW'(idx + 1);
      end
    end
  end

  assign issue = |gnt;
  assign ret   = |tag_q[ADD_LAT-1];

  // Tag shift register and outstanding-add counter
  always_comb begin
    tag_d[0] = gnt;
    for (int s = 1; s < ADD_LAT; s++) tag_d[s] = tag_q[s-1];
    in_flight_d = in_flight_q;
    case ({issue, ret})
      2'b10:   in_flight_d = in_flight_q + 3'd1;
      2'b01:   in_flight_d = in_flight_q - 3'd1;
      default: in_flight_d = in_flight_q;
    endcase
  end

  // State registers; reset drops any adds still in the pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      tag_q       <= '0;
      in_flight_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_q       <= tag_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = tag_q[ADD_LAT-1];
  assign bus.rsp_sum   = add_sum;
  assign in_flight     = in_flight_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: one arbiter with ADD_LAT=1 and one with ADD_LAT=3, each
// driving a behavioural registered adder.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  adder_arbiter_if #(.NREQ(4), .WIDTH(32)) bus1 ();
  adder_arbiter_if #(.NREQ(4), .WIDTH(32)) bus3 ();

  logic [31:0] add_a1, add_b1, add_sum1;
  logic [31:0] add_a3, add_b3, add_sum3;
  logic [2:0]  inf1, inf3;

  adder_arbiter #(.WIDTH(32), .NREQ(4), .ADD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst1), .bus(bus1.slave),
    .add_a(add_a1), .add_b(add_b1), .add_sum(add_sum1), .in_flight(inf1)
  );

  adder_arbiter #(.WIDTH(32), .NREQ(4), .ADD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3), .bus(bus3.slave),
    .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3), .in_flight(inf3)
  );

  // Shared adder models: latency 1 and latency 3, no reset
  logic [31:0] s3 [3];
  always @(posedge clk) begin
    add_sum1 <= add_a1 + add_b1;
    s3[0]    <= add_a3 + add_b3;
    s3[1]    <= s3[0];
    s3[2]    <= s3[1];
  end
  assign add_sum3 = s3[2];

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op1(input int i, input logic [31:0] a, input logic [31:0] b);
    bus1.req_a[i*32 +: 32] = a;
    bus1.req_b[i*32 +: 32] = b;
  endtask

  task automatic op3(input int i, input logic [31:0] a, input logic [31:0] b);
    bus3.req_a[i*32 +: 32] = a;
    bus3.req_b[i*32 +: 32] = b;
  endtask

  initial begin
    rst1 = 1'b0; rst3 = 1'b0;
    bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0;

    // ---------- DUT1: reset behaviour ----------
    cyc(); cyc();
    for (int i = 0; i < 4; i++) op1(i, 32'h100 + i, 32'h200 + i);
    bus1.req_valid = 4'hf;
    @(negedge clk);
    chk("rst_ready", bus1.req_ready, 0);
    chk("rst_add_a", add_a1, 0);
    chk("rst_add_b", add_b1, 0);
    chk("rst_rsp_valid", bus1.rsp_valid, 0);
    chk("rst_in_flight", inf1, 0);
    bus1.req_valid = '0;
    cyc();
    rst1 = 1'b1;
    @(negedge clk);
    chk("post_rst_in_flight", inf1, 0);
    chk("post_rst_rsp_valid", bus1.rsp_valid, 0);

    // ---------- single request ----------
    op1(0, 32'h1, 32'h1);
    bus1.req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", bus1.req_ready, 4'b0001);
    chk("single_add_a", add_a1, 32'h1);
    chk("single_add_b", add_b1, 32'h1);
    cyc();
    bus1.req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", bus1.rsp_valid, 4'b0001);
    chk("single_rsp_sum", bus1.rsp_sum, 32'h2);
    chk("single_in_flight", inf1, 1);
    cyc();
    @(negedge clk);
    chk("single_in_flight_0", inf1, 0);
    chk("single_rsp_done", bus1.rsp_valid, 0);

    // ---------- wrap-around sum (ptr=1, req 2) ----------
    op1(2, 32'hFFFF_FFFF, 32'h1);
    bus1.req_valid = 4'b0100;
    @(negedge clk);
    chk("wrap_ready", bus1.req_ready, 4'b0100);
    cyc();
    bus1.req_valid = '0;
    @(negedge clk);
    chk("wrap_rsp_valid", bus1.rsp_valid, 4'b0100);
    chk("wrap_rsp_sum", bus1.rsp_sum, 32'h0);
    cyc();

    // ---------- pointer skip: move ptr from 3 to 1, then 0 and 3 valid ----------
    bus1.req_valid = 4'b0001;
    @(negedge clk);
    chk("skip_pre_ready", bus1.req_ready, 4'b0001);
    cyc();
    bus1.req_valid = 4'b1001;
    @(negedge clk);
    chk("skip_first_3", bus1.req_ready, 4'b1000);
    cyc();
    bus1.req_valid = 4'b0001;
    @(negedge clk);
    chk("skip_then_0", bus1.req_ready, 4'b0001);
    cyc();
    bus1.req_valid = 4'b0011;
    @(negedge clk);
    chk("skip_ptr_is_1", bus1.req_ready, 4'b0010);
    cyc();
    bus1.req_valid = '0;

    // ---------- idle: ptr (now 2) must not move ----------
    cyc();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_add_a", add_a1, 0);
      chk("idle_add_b", add_b1, 0);
      chk("idle_rsp_valid", bus1.rsp_valid, 0);
      cyc();
    end
    bus1.req_valid = 4'b0101;
    @(negedge clk);
    chk("idle_ptr_kept", bus1.req_ready, 4'b0100);
    cyc();
    bus1.req_valid = '0;
    cyc();

    // ---------- all four continuously from reset ----------
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) op1(i, i, 32'h1234_5678);
    bus1.req_valid = 4'hf;
    cyc();
    rst1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_ready", bus1.req_ready, 64'(1) << (k % 4));
      if (k > 0) begin
        chk("rr_rsp_valid", bus1.rsp_valid, 64'(1) << ((k - 1) % 4));
        chk("rr_rsp_sum", bus1.rsp_sum, 32'h1234_5678 + (k - 1) % 4);
        chk("rr_in_flight", inf1, 1);
      end
      cyc();
    end
    bus1.req_valid = '0;
    @(negedge clk);
    chk("rr_last_valid", bus1.rsp_valid, 4'b1000);
    chk("rr_last_sum", bus1.rsp_sum, 32'h1234_567B);
    cyc();

    // ---------- DUT3: latency 3 ----------
    cyc();
    rst3 = 1'b1;
    op3(2, 32'h10, 32'h20);
    bus3.req_valid = 4'b0100;
    @(negedge clk);
    chk("l3_ready", bus3.req_ready, 4'b0100);
    cyc();
    bus3.req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("l3_rsp_early", bus3.rsp_valid, 0);
      chk("l3_in_flight", inf3, 1);
      cyc();
    end
    @(negedge clk);
    chk("l3_rsp_valid", bus3.rsp_valid, 4'b0100);
    chk("l3_rsp_sum", bus3.rsp_sum, 32'h30);
    cyc();

    // ---------- DUT3: reset mid-operation ----------
    op3(1, 32'h5, 32'h6);
    op3(2, 32'h7, 32'h8);
    bus3.req_valid = 4'b0010;
    @(negedge clk);
    chk("mid_ready0", bus3.req_ready, 4'b0010);
    cyc();
    bus3.req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_ready1", bus3.req_ready, 4'b0100);
    chk("mid_in_flight1", inf3, 1);
    cyc();
    bus3.req_valid = '0;
    @(negedge clk);
    chk("mid_in_flight2", inf3, 2);
    rst3 = 1'b0;
    cyc();
    rst3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", bus3.rsp_valid, 0);
      chk("mid_in_flight0", inf3, 0);
      cyc();
    end
    bus3.req_valid = 4'b1100;
    @(negedge clk);
    chk("mid_lowest_grant", bus3.req_ready, 4'b0100);
    cyc();
    bus3.req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
